// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack memory port arbiter: memory map, widths
// and the fill engine state encoding.
package hack_mem_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 14;

    localparam logic [ADDR_W-1:0] RAM_BASE    = 15'h0000;
    localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;
    localparam logic [ADDR_W-1:0] KBD_ADDR    = 15'h6000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/hack_fill_engine.sv
// Block-fill engine: validates a fill request, then walks address/data
// counters one word per slot the arbiter grants it.
module hack_fill_engine #(
    parameter int                ADDR_W   = hack_mem_pkg::ADDR_W,
    parameter int                DATA_W   = hack_mem_pkg::DATA_W,
    parameter int                LEN_W    = hack_mem_pkg::LEN_W,
    parameter logic [ADDR_W-1:0] KBD_ADDR = hack_mem_pkg::KBD_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill_start,
    input  logic              fill_abort,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [LEN_W-1:0]  fill_len,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [DATA_W-1:0] fill_incr,
    input  logic              slot_taken,
    output logic              slot_valid,
    output logic [ADDR_W-1:0] slot_addr,
    output logic [DATA_W-1:0] slot_data,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              fill_err
);
    import hack_mem_pkg::*;

    localparam int SUM_W = ADDR_W + 1;

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] val_q,   val_d;
    logic [DATA_W-1:0] incr_q,  incr_d;
    logic [LEN_W-1:0]  rem_q,   rem_d;
    logic              err_q,   err_d;
    logic [SUM_W-1:0]  end_sum;

    // One extra bit so a base near the top plus a long length cannot wrap.
    assign end_sum = SUM_W'(fill_base) + SUM_W'(fill_len);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        val_d   = val_q;
        incr_d  = incr_q;
        rem_d   = rem_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    if (fill_len == '0) begin
                        state_d = ST_DONE;
                    end else if (end_sum > SUM_W'(KBD_ADDR)) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = fill_base;
                        val_d   = fill_value;
                        incr_d  = fill_incr;
                        rem_d   = fill_len;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (fill_abort) begin
                    state_d = ST_IDLE;
                end else if (slot_taken) begin
                    addr_d = addr_q + 1'b1;
                    val_d  = val_q + incr_q;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            val_q   <= '0;
            incr_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            val_q   <= val_d;
            incr_q  <= incr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    // An abort kills the slot in the same cycle so no stray write escapes.
    assign slot_valid = (state_q == ST_RUN) && !fill_abort;
    assign slot_addr  = addr_q;
    assign slot_data  = val_q;
    assign fill_busy  = (state_q == ST_RUN);
    assign fill_done  = (state_q == ST_DONE);
    assign fill_err   = err_q;

endmodule

// File: rtl/hack_mem_fill_arbiter.sv
// Owns the Memory port: CPU has absolute priority, the fill engine gets
// every cycle the CPU leaves idle.
module hack_mem_fill_arbiter #(
    parameter int                ADDR_W   = hack_mem_pkg::ADDR_W,
    parameter int                DATA_W   = hack_mem_pkg::DATA_W,
    parameter int                LEN_W    = hack_mem_pkg::LEN_W,
    parameter logic [ADDR_W-1:0] KBD_ADDR = hack_mem_pkg::KBD_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [DATA_W-1:0] cpu_in,
    input  logic              cpu_load,
    input  logic [ADDR_W-1:0] cpu_address,
    output logic [DATA_W-1:0] cpu_out,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_out,
    input  logic              fill_start,
    input  logic              fill_abort,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [LEN_W-1:0]  fill_len,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [DATA_W-1:0] fill_incr,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              fill_err
);
    logic              slot_valid, slot_live, slot_taken;
    logic [ADDR_W-1:0] slot_addr;
    logic [DATA_W-1:0] slot_data;

    hack_fill_engine #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LEN_W   (LEN_W),
        .KBD_ADDR(KBD_ADDR)
    ) u_engine (
        .clk       (clk),
        .reset     (reset),
        .fill_start(fill_start),
        .fill_abort(fill_abort),
        .fill_base (fill_base),
        .fill_len  (fill_len),
        .fill_value(fill_value),
        .fill_incr (fill_incr),
        .slot_taken(slot_taken),
        .slot_valid(slot_valid),
        .slot_addr (slot_addr),
        .slot_data (slot_data),
        .fill_busy (fill_busy),
        .fill_done (fill_done),
        .fill_err  (fill_err)
    );

    // Reset gates the engine off combinationally so a mid-fill reset
    // cannot leak one last write.
    assign slot_live  = slot_valid && reset;
    assign slot_taken = slot_live && !cpu_req;

    always_comb begin
        mem_address = cpu_address;
        mem_in      = '0;
        mem_load    = 1'b0;
        if (cpu_req) begin
            mem_in   = cpu_in;
            mem_load = cpu_load;
        end else if (slot_live) begin
            mem_address = slot_addr;
            mem_in      = slot_data;
            mem_load    = 1'b1;
        end
    end

    assign cpu_out = mem_out;

endmodule

// File: tb/tb_hack_mem_fill_arbiter.sv
// Directed bench for hack_mem_fill_arbiter: screen clear, contention,
// rejection, zero length, abort/reset and CPU passthrough.
module tb_hack_mem_fill_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0;
    logic [15:0] cpu_in = '0;
    logic        cpu_load = 1'b0;
    logic [14:0] cpu_address = '0;
    logic [15:0] cpu_out;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [14:0] mem_address;
    logic [15:0] mem_out = '0;
    logic        fill_start = 1'b0;
    logic        fill_abort = 1'b0;
    logic [14:0] fill_base = '0;
    logic [13:0] fill_len = '0;
    logic [15:0] fill_value = '0;
    logic [15:0] fill_incr = '0;
    logic        fill_busy, fill_done, fill_err;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] wq[$];

    hack_mem_fill_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_in     (cpu_in),
        .cpu_load   (cpu_load),
        .cpu_address(cpu_address),
        .cpu_out    (cpu_out),
        .mem_in     (mem_in),
        .mem_load   (mem_load),
        .mem_address(mem_address),
        .mem_out    (mem_out),
        .fill_start (fill_start),
        .fill_abort (fill_abort),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_value (fill_value),
        .fill_incr  (fill_incr),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .fill_err   (fill_err)
    );

    always #5 clk = ~clk;

    // Log every write the fill side puts on the port (CPU idle, load high).
    always @(negedge clk)
        if (mem_load && !cpu_req) wq.push_back({1'b0, mem_address, mem_in});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wr(input logic [14:0] a, input logic [15:0] d);
        return {1'b0, a, d};
    endfunction

    task automatic start_fill(input logic [14:0] b, input logic [13:0] l,
                              input logic [15:0] v, input logic [15:0] inc);
        fill_base  = b;
        fill_len   = l;
        fill_value = v;
        fill_incr  = inc;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
    endtask

    initial begin
        int cnt;
        int errs;

        // Reset state
        tick();
        tick();
        chk("rst_busy", fill_busy, 0);
        chk("rst_done", fill_done, 0);
        chk("rst_err", fill_err, 0);
        chk("rst_load", mem_load, 0);
        reset = 1'b1;
        tick();

        // 1. Screen clear
        start_fill(15'h4000, 14'd8192, 16'h0000, 16'h0000);
        chk("scr_busy", fill_busy, 1);
        cnt = 0;
        while (fill_busy && cnt < 9000) begin
            cnt++;
            tick();
        end
        chk("scr_busy_cycles", cnt, 8192);
        chk("scr_done", fill_done, 1);
        chk("scr_nwr", wq.size(), 8192);
        errs = 0;
        foreach (wq[i]) if (wq[i] !== wr(15'(15'h4000 + i), 16'h0)) errs++;
        chk("scr_seq", errs, 0);
        tick();
        chk("scr_done_pulse", fill_done, 0);
        wq.delete();

        // 2. Contention with toggling CPU requests
        start_fill(15'h0010, 14'd4, 16'h1000, 16'h0001);
        for (int k = 0; k < 8; k++) begin
            cpu_req     = (k % 2 == 0);
            cpu_address = 15'(15'h0100 + k);
            cpu_in      = 16'(16'hA000 + k);
            cpu_load    = 1'b1;
            #1;
            if (k % 2 == 0) begin
                chk("ct_cpu_addr", mem_address, 15'(15'h0100 + k));
                chk("ct_cpu_data", mem_in, 16'(16'hA000 + k));
                chk("ct_cpu_load", mem_load, 1);
            end else begin
                chk("ct_fill_addr", mem_address, 15'(15'h0010 + k / 2));
                chk("ct_fill_data", mem_in, 16'(16'h1000 + k / 2));
            end
            tick();
        end
        cpu_req  = 1'b0;
        cpu_load = 1'b0;
        chk("ct_done", fill_done, 1);
        chk("ct_nwr", wq.size(), 4);
        errs = 0;
        foreach (wq[i]) if (wq[i] !== wr(15'(15'h0010 + i), 16'(16'h1000 + i))) errs++;
        chk("ct_seq", errs, 0);
        tick();
        wq.delete();

        // 3. Rejection, then the largest legal fill ending at the keyboard
        start_fill(15'h5FFF, 14'd2, 16'h1111, 16'h0);
        chk("rej_err", fill_err, 1);
        chk("rej_busy", fill_busy, 0);
        tick();
        chk("rej_err_pulse", fill_err, 0);
        chk("rej_nwr", wq.size(), 0);
        start_fill(15'h5FFE, 14'd2, 16'h2222, 16'h0);
        chk("acc_busy", fill_busy, 1);
        chk("acc_err", fill_err, 0);
        tick();
        tick();
        chk("acc_done", fill_done, 1);
        chk("acc_nwr", wq.size(), 2);
        if (wq.size() == 2) chk("acc_last", wq[1], wr(15'h5FFF, 16'h2222));
        tick();
        wq.delete();

        // 4. Zero length
        start_fill(15'h0000, 14'd0, 16'h3333, 16'h0);
        chk("z_done", fill_done, 1);
        chk("z_busy", fill_busy, 0);
        tick();
        chk("z_done_pulse", fill_done, 0);
        chk("z_nwr", wq.size(), 0);

        // 5a. Abort after 10 writes
        start_fill(15'h0200, 14'd100, 16'h0005, 16'h0003);
        repeat (10) tick();
        fill_abort = 1'b1;
        #1;
        chk("ab_slot_killed", mem_load, 0);
        tick();
        fill_abort = 1'b0;
        chk("ab_busy", fill_busy, 0);
        errs = 0;
        repeat (4) begin
            if (fill_done) errs++;
            tick();
        end
        chk("ab_no_done", errs, 0);
        chk("ab_nwr", wq.size(), 10);
        if (wq.size() == 10) chk("ab_last", wq[9], wr(15'h0209, 16'h0020));
        wq.delete();

        // 5b. Reset mid-fill
        start_fill(15'h0300, 14'd100, 16'h0000, 16'h0001);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rs_load", mem_load, 0);
        tick();
        chk("rs_busy", fill_busy, 0);
        chk("rs_done", fill_done, 0);
        chk("rs_err", fill_err, 0);
        reset = 1'b1;
        tick();
        chk("rs_busy2", fill_busy, 0);
        chk("rs_nwr", wq.size(), 3);
        wq.delete();

        // 6. CPU passthrough and start ignored while running
        cpu_req     = 1'b1;
        cpu_address = 15'h6000;
        cpu_load    = 1'b0;
        mem_out     = 16'h0041;
        #1;
        chk("pt_out", cpu_out, 16'h0041);
        chk("pt_addr", mem_address, 15'h6000);
        chk("pt_load", mem_load, 0);
        mem_out = 16'h1234;
        #1;
        chk("pt_out2", cpu_out, 16'h1234);
        cpu_req = 1'b0;
        start_fill(15'h0400, 14'd4, 16'h0007, 16'h0000);
        fill_base  = 15'h5FFF;
        fill_len   = 14'd2;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        chk("ig_err", fill_err, 0);
        chk("ig_busy", fill_busy, 1);
        repeat (3) tick();
        chk("ig_done", fill_done, 1);
        chk("ig_nwr", wq.size(), 4);
        if (wq.size() == 4) chk("ig_last", wq[3], wr(15'h0403, 16'h0007));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
